// File: rtl/lcd_bus_scheduler.sv
// HD44780-style 8-bit LCD bus sequencer: power-up init, two-requester
// round-robin arbitration, and setup / enable / hold / execute timing.
module lcd_bus_scheduler #(
    parameter int unsigned SETUP_CYCLES   = 1,
    parameter int unsigned E_CYCLES       = 2,
    parameter int unsigned HOLD_CYCLES    = 1,
    parameter int unsigned EXEC_CYCLES    = 40,
    parameter int unsigned CLEAR_CYCLES   = 1600,
    parameter int unsigned POWERUP_CYCLES = 16000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic       a_rs,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic       b_rs,
    input  logic [7:0] b_data,
    output logic       b_ready,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] db,
    output logic       rs,
    output logic       e
);

    localparam int unsigned MAX_PC = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_PC > EXEC_CYCLES) ? MAX_PC : EXEC_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    typedef logic [CW-1:0] cnt_t;

    // Each timed state lasts N cycles: the counter is loaded with N-1 on entry
    // and the state is left on the cycle the counter reads zero.
    localparam cnt_t SETUP_LD   = cnt_t'(SETUP_CYCLES - 1);
    localparam cnt_t E_LD       = cnt_t'(E_CYCLES - 1);
    localparam cnt_t HOLD_LD    = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t EXEC_LD    = cnt_t'(EXEC_CYCLES - 1);
    localparam cnt_t CLEAR_LD   = cnt_t'(CLEAR_CYCLES - 1);
    localparam cnt_t POWERUP_LD = cnt_t'(POWERUP_CYCLES - 1);

    typedef enum logic [2:0] {
        PWRUP,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        IDLE
    } state_t;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_t;

    state_t     state, state_n;
    cnt_t       cnt, cnt_n;
    logic [7:0] db_q;
    logic       rs_q;
    logic [1:0] init_idx;
    logic       init_done_q;
    req_t       last_grant;
    logic [7:0] init_byte;
    logic       ld_init;
    logic       init_adv;
    logic       init_fin;
    logic       is_clear;

    // Fixed power-up command sequence: 8-bit/2-line, display on, entry mode, clear
    always_comb begin
        case (init_idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    end

    assign is_clear = !rs_q && ((db_q == 8'h01) || (db_q == 8'h02));

    // Round-robin grant: on a tie the requester that did not win last time goes
    assign a_ready = (state == IDLE) && a_valid && (!b_valid || (last_grant == REQ_B));
    assign b_ready = (state == IDLE) && b_valid && (!a_valid || (last_grant == REQ_A));

    assign busy      = (state != IDLE);
    assign e         = (state == PULSE);
    assign db        = db_q;
    assign rs        = rs_q;
    assign init_done = init_done_q;

    // State register and shared down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PWRUP;
            cnt   <= POWERUP_LD;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state, counter reload and datapath strobes
    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == '0) ? cnt : cnt - cnt_t'(1);
        ld_init  = 1'b0;
        init_adv = 1'b0;
        init_fin = 1'b0;
        case (state)
            PWRUP: begin
                if (cnt == '0) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                ld_init = 1'b1;
                state_n = SETUP;
                cnt_n   = SETUP_LD;
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = PULSE;
                    cnt_n   = E_LD;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = EXEC;
                    cnt_n   = is_clear ? CLEAR_LD : EXEC_LD;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    cnt_n = '0;
                    if (!init_done_q && (init_idx != 2'd3)) begin
                        init_adv = 1'b1;
                        state_n  = LOAD;
                    end else begin
                        init_fin = !init_done_q;
                        state_n  = IDLE;
                    end
                end
            end
            IDLE: begin
                if (a_ready || b_ready) begin
                    state_n = SETUP;
                    cnt_n   = SETUP_LD;
                end
            end
            default: begin
                state_n = PWRUP;
                cnt_n   = POWERUP_LD;
            end
        endcase
    end

    // Latched bus byte, init progress and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q        <= '0;
            rs_q        <= 1'b0;
            init_idx    <= '0;
            init_done_q <= 1'b0;
            last_grant  <= REQ_B;
        end else begin
            if (ld_init) begin
                db_q <= init_byte;
                rs_q <= 1'b0;
            end else if (a_ready) begin
                db_q       <= a_data;
                rs_q       <= a_rs;
                last_grant <= REQ_A;
            end else if (b_ready) begin
                db_q       <= b_data;
                rs_q       <= b_rs;
                last_grant <= REQ_B;
            end
            if (init_adv) begin
                init_idx <= init_idx + 2'd1;
            end
            if (init_fin) begin
                init_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: init/first-transfer vector table,
// hand sequences for arbitration, clear timing, reset and dropped requests,
// and a randomized phase checked against a timestamp-based transfer model.
module tb_lcd_bus_scheduler;

    localparam int S_C = 1;
    localparam int E_C = 2;
    localparam int H_C = 1;
    localparam int X_C = 4;
    localparam int C_C = 10;
    localparam int P_C = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0;
    logic       a_rs = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_rs = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       a_ready, b_ready, init_done, busy, rs, e;
    logic [7:0] db;

    always #5 clk = ~clk;

    lcd_bus_scheduler #(
        .SETUP_CYCLES  (S_C),
        .E_CYCLES      (E_C),
        .HOLD_CYCLES   (H_C),
        .EXEC_CYCLES   (X_C),
        .CLEAR_CYCLES  (C_C),
        .POWERUP_CYCLES(P_C)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_valid  (a_valid),
        .a_rs     (a_rs),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_rs     (b_rs),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .init_done(init_done),
        .busy     (busy),
        .db       (db),
        .rs       (rs),
        .e        (e)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: one entry per e pulse ({rs,db} at rise) plus its width
    logic [8:0] seen_q[$];
    int         width_q[$];
    logic       e_d = 1'b0;
    int         wcnt = 0;
    always @(negedge clk) begin
        if (e && !e_d) begin
            seen_q.push_back({rs, db});
            wcnt = 1;
        end else if (e) begin
            wcnt++;
        end else if (e_d) begin
            width_q.push_back(wcnt);
        end
        e_d = e;
    end

    typedef struct {
        int         k;
        logic       av;
        logic       e;
        logic       rs;
        logic [7:0] db;
        logic       busy;
        logic       idn;
        logic       ar;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int k, input logic av, input logic ee, input logic r,
                                input logic [7:0] d, input logic bz, input logic idn, input logic ar);
        vec_t v;
        v.k = k; v.av = av; v.e = ee; v.rs = r; v.db = d; v.busy = bz; v.idn = idn; v.ar = ar;
        tbl.push_back(v);
    endfunction

    function automatic bit is_clear(input logic r, input logic [7:0] d);
        return !r && ((d == 8'h01) || (d == 8'h02));
    endfunction

    // Sample k counts negedges from the one just before reset release
    task automatic run_init_table(input string tag);
        int  s;
        bit  early_e;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_rs    = 1'b1;
        a_data  = 8'h41;
        repeat (3) @(negedge clk);
        s = 0;
        early_e = 0;
        foreach (tbl[i]) begin
            while (s < tbl[i].k) begin
                @(negedge clk);
                s++;
                #1;
                if (s < P_C + 2 && e) early_e = 1;
            end
            a_valid = tbl[i].av;
            #1;
            check($sformatf("%s[%0d].e", tag, s), e, tbl[i].e);
            check($sformatf("%s[%0d].rs", tag, s), rs, tbl[i].rs);
            check($sformatf("%s[%0d].db", tag, s), db, tbl[i].db);
            check($sformatf("%s[%0d].busy", tag, s), busy, tbl[i].busy);
            check($sformatf("%s[%0d].init_done", tag, s), init_done, tbl[i].idn);
            check($sformatf("%s[%0d].a_ready", tag, s), a_ready, tbl[i].ar);
            if (tbl[i].k == 0) rst_n = 1'b1;
        end
        check({tag, ".e_low_during_powerup"}, early_e, 1'b0);
    endtask

    task automatic wait_ready(input bit use_b, output bit got);
        got = 0;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (use_b ? b_ready : a_ready) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One transfer from a single requester; checks bus value, pulse width and busy duration
    task automatic send(input bit use_b, input logic r, input logic [7:0] d, input int wait_exp, input string nm);
        int n;
        bit got;
        @(negedge clk);
        seen_q.delete();
        width_q.delete();
        if (use_b) begin b_valid = 1'b1; b_rs = r; b_data = d; end
        else       begin a_valid = 1'b1; a_rs = r; a_data = d; end
        wait_ready(use_b, got);
        check({nm, ".handshake"}, got, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        check({nm, ".db"}, {rs, db}, {r, d});
        n = 1;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
            #1;
        end
        check({nm, ".cycles_to_idle"}, n, 1 + S_C + E_C + H_C + wait_exp);
        check({nm, ".pulses"}, seen_q.size(), 1);
        check({nm, ".pulse_byte"}, (seen_q.size() > 0) ? seen_q[0] : 9'h1FF, {r, d});
        check({nm, ".pulse_width"}, (width_q.size() > 0) ? width_q[0] : 0, E_C);
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit both;
        int n;

        // Power-up init with A requesting from reset, then A's 0x41 transfer
        add(0,  1, 0, 0, 8'h00, 1, 0, 0);
        add(19, 1, 0, 0, 8'h00, 1, 0, 0);
        add(20, 1, 0, 0, 8'h00, 1, 0, 0);
        add(21, 1, 0, 0, 8'h38, 1, 0, 0);
        add(22, 1, 1, 0, 8'h38, 1, 0, 0);
        add(23, 1, 1, 0, 8'h38, 1, 0, 0);
        add(24, 1, 0, 0, 8'h38, 1, 0, 0);
        add(29, 1, 0, 0, 8'h38, 1, 0, 0);
        add(30, 1, 0, 0, 8'h0C, 1, 0, 0);
        add(31, 1, 1, 0, 8'h0C, 1, 0, 0);
        add(32, 1, 1, 0, 8'h0C, 1, 0, 0);
        add(33, 1, 0, 0, 8'h0C, 1, 0, 0);
        add(40, 1, 1, 0, 8'h06, 1, 0, 0);
        add(41, 1, 1, 0, 8'h06, 1, 0, 0);
        add(42, 1, 0, 0, 8'h06, 1, 0, 0);
        add(49, 1, 1, 0, 8'h01, 1, 0, 0);
        add(50, 1, 1, 0, 8'h01, 1, 0, 0);
        add(51, 1, 0, 0, 8'h01, 1, 0, 0);
        add(61, 1, 0, 0, 8'h01, 1, 0, 0);
        add(62, 1, 0, 0, 8'h01, 0, 1, 1);
        add(63, 0, 0, 1, 8'h41, 1, 1, 0);
        add(64, 0, 1, 1, 8'h41, 1, 1, 0);
        add(65, 0, 1, 1, 8'h41, 1, 1, 0);
        add(66, 0, 0, 1, 8'h41, 1, 1, 0);
        add(70, 0, 0, 1, 8'h41, 1, 1, 0);
        add(71, 0, 0, 1, 8'h41, 0, 1, 0);

        run_init_table("init");

        // Reset asserted in the second e-high cycle of a transfer
        @(negedge clk);
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h55;
        wait_ready(1'b0, got);
        check("rst.handshake", got, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.pre_e", e, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst.e", e, 1'b0);
        check("rst.db", db, 8'h00);
        check("rst.init_done", init_done, 1'b0);
        check("rst.busy", busy, 1'b1);
        run_init_table("rerun");

        // Make B the last grant, then both request continuously
        send(1'b1, 1'b1, 8'h20, X_C, "b_pre");
        @(negedge clk);
        seen_q.delete();
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h41;
        b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h42;
        both = 0;
        n = 0;
        while (seen_q.size() < 4 && n < 200) begin
            #1;
            if (a_ready && b_ready) both = 1;
            @(negedge clk);
            n++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("rr.both_ready", both, 1'b0);
        check("rr.count", seen_q.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr.order[%0d]", i), (seen_q.size() > i) ? seen_q[i] : 9'h1FF,
                  (i % 2 == 0) ? 9'h141 : 9'h142);
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; #1; end
        check("rr.idle", busy, 1'b0);

        // Clear command waits CLEAR cycles; an ordinary command waits EXEC cycles
        send(1'b1, 1'b0, 8'h01, C_C, "clear");
        send(1'b0, 1'b0, 8'h80, X_C, "cmd");
        send(1'b0, 1'b0, 8'h02, C_C, "home");

        // A pulses valid for one cycle during EXEC: no handshake, no extra bus activity
        @(negedge clk);
        seen_q.delete();
        b_valid = 1'b1; b_rs = 1'b1; b_data = 8'h33;
        wait_ready(1'b1, got);
        check("drop.handshake", got, 1'b1);
        n = 0;
        repeat (6) begin @(negedge clk); n++; b_valid = 1'b0; end
        a_valid = 1'b1; a_rs = 1'b1; a_data = 8'h77;
        #1;
        check("drop.a_ready", a_ready, 1'b0);
        check("drop.b_ready", b_ready, 1'b0);
        check("drop.busy", busy, 1'b1);
        @(negedge clk);
        n++;
        a_valid = 1'b0;
        #1;
        while (busy && n < 100) begin @(negedge clk); n++; #1; end
        check("drop.cycles_to_idle", n, 1 + S_C + E_C + H_C + X_C);
        repeat (10) @(negedge clk);
        #1;
        check("drop.pulses", seen_q.size(), 1);
        check("drop.still_idle", busy, 1'b0);

        // Randomized phase against a timestamp model of transfers
        begin
            int   free_at, ac, last;
            logic cur_rs;
            logic [7:0] cur_db;
            bit   acc_a, acc_b, idle, ea, eb, ee;
            int   d;
            rst_n = 1'b0;
            a_valid = 1'b0;
            b_valid = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            n = 0;
            #1;
            while (busy && n < 200) begin @(negedge clk); n++; #1; end
            check("rand.init_done", init_done, 1'b1);
            free_at = 0; ac = -1000; last = 1; cur_rs = 1'b0; cur_db = 8'h01;
            acc_a = 0; acc_b = 0;
            for (int c = 0; c < 600; c++) begin
                if (c > 0) @(negedge clk);
                if (acc_a || (!a_valid && $urandom_range(2) == 0)) begin
                    a_valid = $urandom_range(1);
                    a_rs = $urandom_range(1); a_data = 8'($urandom);
                    if ($urandom_range(4) == 0) begin a_rs = 1'b0; a_data = $urandom_range(1) ? 8'h01 : 8'h02; end
                end else if (a_valid && $urandom_range(9) == 0) begin
                    a_valid = 1'b0;
                end
                if (acc_b || (!b_valid && $urandom_range(2) == 0)) begin
                    b_valid = $urandom_range(1);
                    b_rs = $urandom_range(1); b_data = 8'($urandom);
                    if ($urandom_range(4) == 0) begin b_rs = 1'b0; b_data = $urandom_range(1) ? 8'h01 : 8'h02; end
                end else if (b_valid && $urandom_range(9) == 0) begin
                    b_valid = 1'b0;
                end
                #1;
                idle = (c >= free_at);
                ea = idle && a_valid && (!b_valid || last == 1);
                eb = idle && b_valid && (!a_valid || last == 0);
                d  = c - ac;
                ee = (d > S_C) && (d <= S_C + E_C);
                check($sformatf("rand[%0d].a_ready", c), a_ready, ea);
                check($sformatf("rand[%0d].b_ready", c), b_ready, eb);
                check($sformatf("rand[%0d].busy", c), busy, !idle);
                check($sformatf("rand[%0d].e", c), e, ee);
                check($sformatf("rand[%0d].bus", c), {rs, db}, {cur_rs, cur_db});
                acc_a = ea;
                acc_b = eb;
                if (ea || eb) begin
                    ac = c;
                    cur_rs = ea ? a_rs : b_rs;
                    cur_db = ea ? a_data : b_data;
                    last = ea ? 0 : 1;
                    free_at = c + 1 + S_C + E_C + H_C + (is_clear(cur_rs, cur_db) ? C_C : X_C);
                end
            end
            a_valid = 1'b0;
            b_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
